// File: rtl/dma_rd_pkg.sv
// Shared types for the DMA read channel.
//   cl_addr_t : cache-line address (64-byte lines)
//   count_t   : line counters, one bit wider than the address so a full
//               2^CL_ADDR_WIDTH transfer cannot overflow
//   state_t   : channel FSM states; the encodings also exist as plain
//               localparams for legacy code that compares raw state bits
package dma_rd_pkg;

    localparam int DMA_CL_ADDR_WIDTH = 42;
    localparam int DMA_SIZE_WIDTH    = DMA_CL_ADDR_WIDTH + 1;

    typedef logic [DMA_CL_ADDR_WIDTH-1:0] cl_addr_t;
    typedef logic [DMA_SIZE_WIDTH-1:0]    count_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACTIVE = ST_ACTIVE,
        DONE   = ST_DONE
    } state_t;

endpackage

// File: rtl/dma_rd_channel_if.sv
// Host memory read interface of the DMA read channel.
//   req_valid/req_addr/req_ready : one cache-line read request per handshake
//   resp_valid/resp_data         : in-order response lines, no backpressure
// master = the DMA channel, slave = the memory side.
interface dma_rd_channel_if #(
    parameter int CL_ADDR_WIDTH = 42,
    parameter int DATA_WIDTH    = 512
);
    logic                     req_valid;
    logic [CL_ADDR_WIDTH-1:0] req_addr;
    logic                     req_ready;
    logic                     resp_valid;
    logic [DATA_WIDTH-1:0]    resp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_data
    );
endinterface

// File: rtl/dma_fifo.sv
// Single-clock show-ahead FIFO.
//   wr_en/wr_data : push (ignored while full)
//   rd_en         : pop the head (ignored while empty)
//   rd_data       : current head, valid while empty=0, reads 0 when empty
//   empty/full    : status decoded from the occupancy count
//   count         : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module dma_fifo
    import dma_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 64,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [AW:0]           count
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;

    // Forcing the head to zero while empty gives a defined rd_data out of
    // reset without needing a reset on the storage array.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_push  = wr_en && !full;
        do_pop   = rd_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/dma_rd_channel.sv
// DMA read channel.
//   clk, rst          : single clock, asynchronous active-low reset
//   rd_addr/rd_size   : start byte address and line count, latched on rd_go
//   rd_go             : start pulse, honoured in IDLE or DONE only
//   rd_en/rd_data     : AFU pop and show-ahead FIFO head
//   empty             : no line available to the AFU
//   rd_done           : all rd_size lines have been popped
//   mem               : host memory request/response interface (master)
// Requests are issued only while outstanding lines plus buffered lines stay
// below FIFO_DEPTH, so every response is guaranteed a FIFO slot.
module dma_rd_channel
    import dma_rd_pkg::*;
#(
    parameter int ADDR_WIDTH    = 64,
    parameter int CL_ADDR_WIDTH = 42,
    parameter int SIZE_WIDTH    = CL_ADDR_WIDTH + 1,
    parameter int DATA_WIDTH    = 512,
    parameter int FIFO_DEPTH    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [SIZE_WIDTH-1:0] rd_size,
    input  logic                  rd_go,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  rd_done,
    dma_rd_channel_if.master      mem
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    state_t                   state_q, state_d;
    logic [CL_ADDR_WIDTH-1:0] cl_addr_q, cl_addr_d;
    logic [SIZE_WIDTH-1:0]    size_q, size_d;
    logic [SIZE_WIDTH-1:0]    req_count_q, req_count_d;
    logic [SIZE_WIDTH-1:0]    resp_count_q, resp_count_d;
    logic [SIZE_WIDTH-1:0]    pop_count_q, pop_count_d;
    logic                     req_valid_q, req_valid_d;
    logic [CL_ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                     rd_done_q, rd_done_d;

    logic                     push, pop, accept;
    logic                     fifo_empty, fifo_full;
    logic [FCW-1:0]           fifo_count;
    logic [SIZE_WIDTH-1:0]    credit_used;
    logic                     unused_rd_addr;

    // Low six bits select a byte inside a line; upper bits beyond the
    // line address are don't-care.
    assign unused_rd_addr = ^rd_addr;

    assign mem.req_valid = req_valid_q;
    assign mem.req_addr  = req_addr_q;
    assign rd_done       = rd_done_q;
    assign empty         = fifo_empty;

    always_comb begin
        state_d      = state_q;
        cl_addr_d    = cl_addr_q;
        size_d       = size_q;
        req_count_d  = req_count_q;
        resp_count_d = resp_count_q;
        pop_count_d  = pop_count_q;
        rd_done_d    = rd_done_q;

        accept = req_valid_q && mem.req_ready;
        // Responses with no matching outstanding request, or with nowhere
        // to go, are dropped rather than corrupting the counters.
        push   = mem.resp_valid && (resp_count_q < req_count_q) && !fifo_full;
        pop    = rd_en && !fifo_empty;

        unique case (state_q)
            IDLE, DONE: begin
                if (rd_go) begin
                    cl_addr_d    = rd_addr[CL_ADDR_WIDTH+5:6];
                    size_d       = rd_size;
                    req_count_d  = '0;
                    resp_count_d = '0;
                    pop_count_d  = '0;
                    if (rd_size == '0) begin
                        state_d   = DONE;
                        rd_done_d = 1'b1;
                    end else begin
                        state_d   = ACTIVE;
                        rd_done_d = 1'b0;
                    end
                end
            end
            ACTIVE: begin
                if (accept) begin
                    req_count_d = req_count_q + SIZE_WIDTH'(1);
                end
                if (push) begin
                    resp_count_d = resp_count_q + SIZE_WIDTH'(1);
                end
                if (pop) begin
                    pop_count_d = pop_count_q + SIZE_WIDTH'(1);
                end
                if (pop_count_d == size_q) begin
                    state_d   = DONE;
                    rd_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The request flop is computed from next-cycle counts so it is
        // already exact when it is presented. Since a response moves a line
        // from outstanding into the FIFO, credit_used can only grow through
        // an accepted request, which keeps a presented request stable.
        credit_used = (req_count_d - resp_count_d)
                    + SIZE_WIDTH'(fifo_count)
                    + SIZE_WIDTH'(push)
                    - SIZE_WIDTH'(pop);
        req_valid_d = (state_d == ACTIVE)
                   && (req_count_d < size_d)
                   && (credit_used < SIZE_WIDTH'(FIFO_DEPTH));
        req_addr_d  = cl_addr_d + req_count_d[CL_ADDR_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cl_addr_q    <= '0;
            size_q       <= '0;
            req_count_q  <= '0;
            resp_count_q <= '0;
            pop_count_q  <= '0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            rd_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cl_addr_q    <= cl_addr_d;
            size_q       <= size_d;
            req_count_q  <= req_count_d;
            resp_count_q <= resp_count_d;
            pop_count_q  <= pop_count_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            rd_done_q    <= rd_done_d;
        end
    end

    dma_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .wr_en   (push),
        .wr_data (mem.resp_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    resp_protocol_a: assert property (
        @(posedge clk) disable iff (!rst)
        mem.resp_valid |-> ((resp_count_q < req_count_q) && !fifo_full)
    );

endmodule

// File: tb/tb_dma_rd_channel.sv
module tb_dma_rd_channel;
    import dma_rd_pkg::*;

    logic         clk;
    logic         rst;
    logic [63:0]  rd_addr;
    logic [42:0]  rd_size;
    logic         rd_go;
    logic         rd_en;
    logic [511:0] rd_data;
    logic         empty;
    logic         rd_done;

    dma_rd_channel_if #(.CL_ADDR_WIDTH(42), .DATA_WIDTH(512)) mif ();

    dma_rd_channel #(
        .ADDR_WIDTH    (64),
        .CL_ADDR_WIDTH (42),
        .SIZE_WIDTH    (43),
        .DATA_WIDTH    (512),
        .FIFO_DEPTH    (64)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (rd_addr),
        .rd_size (rd_size),
        .rd_go   (rd_go),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .rd_done (rd_done),
        .mem     (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 3;

    logic [41:0]  acc_addr [$];
    int           acc_cyc  [$];
    logic [511:0] pop_data [$];
    int           pop_cyc  [$];
    logic [41:0]  pend_addr[$];
    int           pend_due [$];

    function automatic logic [511:0] data_of(input logic [41:0] a);
        logic [63:0] w;
        w = {a, 22'h2B5C3} ^ 64'hC3A5_0F1E_7788_9911;
        return {8{w}};
    endfunction

    // Memory model, request side: log accepted requests and AFU pops.
    always @(posedge clk) begin
        if (rst) begin
            if (mif.req_valid && mif.req_ready) begin
                acc_addr.push_back(mif.req_addr);
                acc_cyc.push_back(cyc);
                pend_addr.push_back(mif.req_addr);
                pend_due.push_back(cyc + lat);
            end
            if (rd_en && !empty) begin
                pop_data.push_back(rd_data);
                pop_cyc.push_back(cyc);
            end
        end
        cyc <= cyc + 1;
    end

    // Memory model, response side: in-order lines after lat cycles.
    always @(negedge clk) begin
        if (!rst) begin
            pend_addr.delete();
            pend_due.delete();
            mif.resp_valid = 1'b0;
            mif.resp_data  = '0;
        end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            mif.resp_valid = 1'b1;
            mif.resp_data  = data_of(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            mif.resp_valid = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_addr.delete();
        acc_cyc.delete();
        pop_data.delete();
        pop_cyc.delete();
    endtask

    task automatic start(input logic [63:0] a, input logic [42:0] s, output int gcyc);
        rd_addr = a;
        rd_size = s;
        rd_go   = 1'b1;
        gcyc    = cyc;
        tick();
        rd_go   = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int dcyc, output bit ok);
        ok   = 1'b0;
        dcyc = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (rd_done) begin
                ok   = 1'b1;
                dcyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        rd_addr       = '0;
        rd_size       = '0;
        rd_go         = 1'b0;
        rd_en         = 1'b0;
        mif.req_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        total++; if (rd_done !== 1'b0) begin bad++; $display("FAIL reset_rd_done: got %b want 0", rd_done); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
        total++; if (mif.req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", mif.req_valid); end
        total++; if (mif.req_addr !== 42'h0) begin bad++; $display("FAIL reset_req_addr: got %h want 0", mif.req_addr); end
        total++; if (rd_data !== 512'h0) begin bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    endtask

    task automatic test_zero_size();
        int g;
        int seen;
        clear_logs();
        mif.req_ready = 1'b1;
        rd_en = 1'b1;
        tick();
        start(64'h5000, 43'd0, g);
        @(negedge clk);
        total++; if (rd_done !== 1'b1) begin bad++; $display("FAIL zero_rd_done: got %b want 1", rd_done); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL zero_empty: got %b want 1", empty); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            if (mif.req_valid === 1'b1) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL zero_req_valid: got %0d cycles want 0", seen); end
        total++; if (acc_addr.size() !== 0) begin bad++; $display("FAIL zero_requests: got %0d want 0", acc_addr.size()); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL zero_empty_hold: got %b want 1", empty); end
    endtask

    task automatic test_basic();
        int g, d;
        bit ok;
        tick();
        lat = 3;
        mif.req_ready = 1'b1;
        rd_en = 1'b1;
        clear_logs();
        start(64'h1000, 43'd4, g);
        @(negedge clk);
        total++; if (rd_done !== 1'b0) begin bad++; $display("FAIL basic_done_clr: got %b want 0", rd_done); end
        total++; if (mif.req_valid !== 1'b1) begin bad++; $display("FAIL basic_first_valid: got %b want 1", mif.req_valid); end
        total++; if (mif.req_addr !== 42'h40) begin bad++; $display("FAIL basic_first_addr: got %h want 40", mif.req_addr); end
        wait_done(200, d, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout: got rd_done=0 want 1"); end
        total++; if (acc_addr.size() !== 4) begin bad++; $display("FAIL basic_req_count: got %0d want 4", acc_addr.size()); end
        for (int i = 0; i < 4 && i < acc_addr.size(); i++) begin
            total++; if (acc_addr[i] !== 42'(64 + i)) begin bad++; $display("FAIL basic_addr[%0d]: got %h want %h", i, acc_addr[i], 42'(64 + i)); end
            total++; if (acc_cyc[i] !== g + 1 + i) begin bad++; $display("FAIL basic_req_cycle[%0d]: got %0d want %0d", i, acc_cyc[i], g + 1 + i); end
        end
        total++; if (pop_data.size() !== 4) begin bad++; $display("FAIL basic_pops: got %0d want 4", pop_data.size()); end
        for (int i = 0; i < 4 && i < pop_data.size(); i++) begin
            total++; if (pop_data[i] !== data_of(42'(64 + i))) begin bad++; $display("FAIL basic_data[%0d]: got %h want %h", i, pop_data[i], data_of(42'(64 + i))); end
        end
        if (pop_cyc.size() == 4) begin
            total++; if (d !== pop_cyc[3] + 1) begin bad++; $display("FAIL basic_done_cycle: got %0d want %0d", d, pop_cyc[3] + 1); end
        end
    endtask

    task automatic test_backpressure();
        int g, d;
        bit ok;
        tick();
        lat = 3;
        mif.req_ready = 1'b1;
        rd_en = 1'b0;
        clear_logs();
        start(64'h4000, 43'd200, g);
        repeat (150) tick();
        @(negedge clk);
        total++; if (acc_addr.size() !== 64) begin bad++; $display("FAIL bp_credit_reqs: got %0d want 64", acc_addr.size()); end
        total++; if (mif.req_valid !== 1'b0) begin bad++; $display("FAIL bp_req_stalled: got %b want 0", mif.req_valid); end
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL bp_fifo_has_data: got %b want 0", empty); end
        tick();
        rd_en = 1'b1;
        wait_done(2000, d, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_timeout: got rd_done=0 want 1"); end
        total++; if (acc_addr.size() !== 200) begin bad++; $display("FAIL bp_total_reqs: got %0d want 200", acc_addr.size()); end
        total++; if (pop_data.size() !== 200) begin bad++; $display("FAIL bp_total_pops: got %0d want 200", pop_data.size()); end
        for (int i = 0; i < 200 && i < pop_data.size(); i++) begin
            total++; if (pop_data[i] !== data_of(42'(256 + i))) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, pop_data[i], data_of(42'(256 + i))); end
        end
        for (int i = 0; i < 200 && i < acc_addr.size(); i++) begin
            total++; if (acc_addr[i] !== 42'(256 + i)) begin bad++; $display("FAIL bp_addr[%0d]: got %h want %h", i, acc_addr[i], 42'(256 + i)); end
        end
    endtask

    task automatic test_stalls();
        int g;
        bit ok;
        tick();
        lat = 3;
        clear_logs();
        mif.req_ready = 1'b0;
        rd_en = 1'b1;
        start(64'h8000, 43'd100, g);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            mif.req_ready = 1'($urandom_range(0, 1));
            rd_en = ($urandom_range(0, 3) != 0);
            tick();
            if (rd_done) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (!ok) begin bad++; $display("FAIL stall_timeout: got rd_done=0 want 1"); end
        for (int i = 0; i < 10; i++) begin
            rd_en = 1'($urandom_range(0, 1));
            tick();
        end
        @(negedge clk);
        total++; if (pop_data.size() !== 100) begin bad++; $display("FAIL stall_pops: got %0d want 100", pop_data.size()); end
        total++; if (acc_addr.size() !== 100) begin bad++; $display("FAIL stall_reqs: got %0d want 100", acc_addr.size()); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL stall_empty_end: got %b want 1", empty); end
        for (int i = 0; i < 100 && i < pop_data.size(); i++) begin
            total++; if (pop_data[i] !== data_of(42'(512 + i))) begin bad++; $display("FAIL stall_data[%0d]: got %h want %h", i, pop_data[i], data_of(42'(512 + i))); end
        end
    endtask

    task automatic test_wrap();
        int g, d;
        bit ok;
        logic [41:0] exp_a [3];
        exp_a[0] = 42'h3FF_FFFF_FFFF;
        exp_a[1] = 42'h0;
        exp_a[2] = 42'h1;
        tick();
        lat = 3;
        mif.req_ready = 1'b1;
        rd_en = 1'b1;
        clear_logs();
        start(64'hFFFF_FFFF_FFFF_FFC0, 43'd3, g);
        wait_done(200, d, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_timeout: got rd_done=0 want 1"); end
        total++; if (acc_addr.size() !== 3) begin bad++; $display("FAIL wrap_reqs: got %0d want 3", acc_addr.size()); end
        for (int i = 0; i < 3 && i < acc_addr.size(); i++) begin
            total++; if (acc_addr[i] !== exp_a[i]) begin bad++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, acc_addr[i], exp_a[i]); end
        end
        for (int i = 0; i < 3 && i < pop_data.size(); i++) begin
            total++; if (pop_data[i] !== data_of(exp_a[i])) begin bad++; $display("FAIL wrap_data[%0d]: got %h want %h", i, pop_data[i], data_of(exp_a[i])); end
        end
    endtask

    task automatic test_reset_mid();
        int g, d;
        bit ok;
        tick();
        lat = 10;
        mif.req_ready = 1'b1;
        rd_en = 1'b0;
        clear_logs();
        start(64'h2_0000, 43'd200, g);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (acc_addr.size() >= 20) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        total++; if (!ok) begin bad++; $display("FAIL rstmid_reach: got %0d reqs want 20", acc_addr.size()); end
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL rstmid_pre_empty: got %b want 0", empty); end
        rst = 1'b0;
        #1;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rstmid_empty: got %b want 1", empty); end
        total++; if (mif.req_valid !== 1'b0) begin bad++; $display("FAIL rstmid_req_valid: got %b want 0", mif.req_valid); end
        total++; if (rd_done !== 1'b0) begin bad++; $display("FAIL rstmid_rd_done: got %b want 0", rd_done); end
        repeat (3) tick();
        @(negedge clk);
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rstmid_empty_hold: got %b want 1", empty); end
        tick();
        rst = 1'b1;
        lat = 3;
        rd_en = 1'b1;
        clear_logs();
        tick();
        start(64'hC000, 43'd2, g);
        wait_done(200, d, ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_timeout: got rd_done=0 want 1"); end
        repeat (5) tick();
        total++; if (pop_data.size() !== 2) begin bad++; $display("FAIL rstmid_pops: got %0d want 2", pop_data.size()); end
        total++; if (acc_addr.size() !== 2) begin bad++; $display("FAIL rstmid_reqs: got %0d want 2", acc_addr.size()); end
        for (int i = 0; i < 2 && i < pop_data.size(); i++) begin
            total++; if (pop_data[i] !== data_of(42'(768 + i))) begin bad++; $display("FAIL rstmid_data[%0d]: got %h want %h", i, pop_data[i], data_of(42'(768 + i))); end
        end
    endtask

    initial begin
        test_reset();
        test_zero_size();
        test_basic();
        test_backpressure();
        test_stalls();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1);
    end

endmodule
